// File: rtl/led_pwm_fader_if.sv
// led_pwm_fader_if -- LED request / drive bundle for the PWM fader.
//
// Signals (3 channels, polarity set by the fader's ACTIVE_LOW parameter):
//   led_in  : requested on/off pattern from the upstream blink/rotate stage
//   pwm_out : registered PWM drive to the board LEDs
//   settled : per-channel flag, 1 when the channel sits at its target extreme
//
// Modports:
//   master : upstream/bench side, drives led_in and observes the outputs
//   slave  : fader side, consumes led_in and drives pwm_out / settled
interface led_pwm_fader_if;
   logic [2:0] led_in;
   logic [2:0] pwm_out;
   logic [2:0] settled;

   modport master (output led_in, input pwm_out, input settled);
   modport slave  (input led_in, output pwm_out, output settled);
endinterface

// File: rtl/led_pwm_fader.sv
// led_pwm_fader -- three-channel LED brightness fader.
//
// Each channel ramps its brightness level one step at a time towards full-on
// or full-off, following the requested pattern on led_in. The level is turned
// into a PWM waveform by comparing it with a free-running counter.
//
// Parameters:
//   PWM_BITS   : width of the PWM counter and brightness levels
//   STEP_CLKS  : clocks per brightness step (>= 1)
//   ACTIVE_LOW : 1 -> a 0 bit means "LED on" on both led_in and pwm_out
//
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : slave side of led_pwm_fader_if (led_in in, pwm_out/settled out)
module led_pwm_fader #(
   parameter int PWM_BITS   = 8,
   parameter int STEP_CLKS  = 52734,
   parameter int ACTIVE_LOW = 1
) (
   input  logic            clk,
   input  logic            rst_n,
   led_pwm_fader_if.slave  bus
);

   // STEP_CLKS = 1 still needs a one-bit counter that never leaves 0.
   localparam int SC_W = (STEP_CLKS > 1) ? $clog2(STEP_CLKS) : 1;
   localparam logic [SC_W-1:0]     STEP_LAST = SC_W'(STEP_CLKS - 1);
   localparam logic [PWM_BITS-1:0] LVL_MAX   = '1;
   localparam logic                OFF_BIT   = (ACTIVE_LOW != 0);
   localparam logic                ON_BIT    = ~OFF_BIT;

   logic [2:0]                led_q;
   logic [PWM_BITS-1:0]       pwm_cnt;
   logic [SC_W-1:0]           step_cnt;
   logic                      step_tick;
   logic [2:0][PWM_BITS-1:0]  level;
   logic [2:0][PWM_BITS-1:0]  level_nxt;
   logic [2:0]                target_on;
   logic [2:0]                pwm_nxt;
   logic [2:0]                settled_nxt;
   logic [2:0]                pwm_q;
   logic [2:0]                settled_q;

   // One saturating brightness step towards the target extreme.
   function automatic logic [PWM_BITS-1:0] step_level(
      input logic [PWM_BITS-1:0] cur,
      input logic                up
   );
      logic [PWM_BITS-1:0] res;
      res = cur;
      if (up && (cur != LVL_MAX)) begin
         res = cur + PWM_BITS'(1);
      end else if (!up && (cur != '0)) begin
         res = cur - PWM_BITS'(1);
      end
      return res;
   endfunction

   // Full scale is lit continuously so the top level has no one-clock dark gap.
   function automatic logic is_lit(
      input logic [PWM_BITS-1:0] lvl,
      input logic [PWM_BITS-1:0] cnt
   );
      return (lvl == LVL_MAX) || (cnt < lvl);
   endfunction

   always_comb begin
      step_tick   = (step_cnt == STEP_LAST);
      target_on   = '0;
      level_nxt   = level;
      pwm_nxt     = {3{OFF_BIT}};
      settled_nxt = '0;
      for (int i = 0; i < 3; i++) begin
         target_on[i] = (led_q[i] == ON_BIT);
         if (step_tick) begin
            level_nxt[i] = step_level(level[i], target_on[i]);
         end
         pwm_nxt[i]     = is_lit(level[i], pwm_cnt) ? ON_BIT : OFF_BIT;
         settled_nxt[i] = target_on[i] ? (level[i] == LVL_MAX) : (level[i] == '0);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         led_q     <= {3{OFF_BIT}};
         pwm_cnt   <= '0;
         step_cnt  <= '0;
         level     <= '0;
         pwm_q     <= {3{OFF_BIT}};
         settled_q <= 3'b111;
      end else begin
         led_q     <= bus.led_in;
         pwm_cnt   <= pwm_cnt + PWM_BITS'(1);
         step_cnt  <= step_tick ? '0 : step_cnt + SC_W'(1);
         level     <= level_nxt;
         pwm_q     <= pwm_nxt;
         settled_q <= settled_nxt;
      end
   end

   assign bus.pwm_out = pwm_q;
   assign bus.settled = settled_q;

endmodule

// File: tb/tb_led_pwm_fader.sv
// tb_led_pwm_fader -- bench for led_pwm_fader (STEP_CLKS=4, PWM_BITS=8,
// ACTIVE_LOW=1). A behavioural model tracks brightness as plain integers
// and the outputs are compared with it on every falling clock edge.
module tb_led_pwm_fader;
   localparam int STEP = 4;
   localparam int MAXL = 255;
   localparam int PER  = 256;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   errors = 0;
   int   checks = 0;
   logic chk_en = 1'b0;

   led_pwm_fader_if bus ();

   led_pwm_fader #(.PWM_BITS(8), .STEP_CLKS(STEP), .ACTIVE_LOW(1)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Model state: brightness per channel, clocks since reset release,
   // the input pattern the fader currently acts on, and expected outputs.
   int         m_level [3] = '{0, 0, 0};
   int         m_n = 0;
   logic [2:0] m_req = 3'b111;
   logic [2:0] e_pwm = 3'b111;
   logic [2:0] e_set = 3'b111;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 3; i++) m_level[i] = 0;
         m_n   = 0;
         m_req = 3'b111;
         e_pwm = 3'b111;
         e_set = 3'b111;
      end else begin
         for (int i = 0; i < 3; i++) begin
            bit want_on;
            want_on  = (m_req[i] == 1'b0);
            // Outputs seen after this edge reflect brightness and counter before it.
            e_pwm[i] = ((m_level[i] == MAXL) || ((m_n % PER) < m_level[i])) ? 1'b0 : 1'b1;
            e_set[i] = want_on ? (m_level[i] == MAXL) : (m_level[i] == 0);
            // Every STEP-th clock after release moves each level one notch.
            if ((m_n % STEP) == STEP - 1) begin
               if (want_on && m_level[i] < MAXL) m_level[i] = m_level[i] + 1;
               else if (!want_on && m_level[i] > 0) m_level[i] = m_level[i] - 1;
            end
         end
         m_req = bus.led_in;
         m_n   = m_n + 1;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check("pwm_out", 32'(bus.pwm_out), 32'(e_pwm));
         check("settled", 32'(bus.settled), 32'(e_set));
      end
   end

   task automatic ticks(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset(input int hold);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_pwm", 32'(bus.pwm_out), 32'h7);
      check("async_rst_set", 32'(bus.settled), 32'h7);
      ticks(hold);
      #2 rst_n = 1'b1;
   endtask

   initial begin
      bus.led_in = 3'b000;
      ticks(3);
      chk_en = 1'b1;
      check("reset_pwm", 32'(bus.pwm_out), 32'h7);
      check("reset_set", 32'(bus.settled), 32'h7);

      // Fade-in of channel 0 from reset.
      bus.led_in = 3'b110;
      #2 rst_n = 1'b1;
      ticks(3);
      check("fade_lvl_3clk", 32'(m_level[0]), 32'd0);
      ticks(1);
      check("fade_lvl_4clk", 32'(m_level[0]), 32'd1);
      ticks(1016);
      check("fade_lvl_1020", 32'(m_level[0]), 32'd255);
      check("fade_set_1020", 32'(bus.settled), 32'h6);
      ticks(1);
      check("fade_set_1021", 32'(bus.settled), 32'h7);
      check("fade_pwm0_on", 32'(bus.pwm_out[0]), 32'h0);

      // Ramp channel 2 to 37, then reset mid-ramp.
      bus.led_in = 3'b011;
      do_reset(3);
      ticks(148);
      check("ramp_lvl_37", 32'(m_level[2]), 32'd37);
      do_reset(3);
      ticks(3);
      check("restart_lvl_3", 32'(m_level[2]), 32'd0);
      ticks(1);
      check("restart_lvl_4", 32'(m_level[2]), 32'd1);

      // Reversal at level 100.
      ticks(396);
      check("rev_lvl_100", 32'(m_level[2]), 32'd100);
      bus.led_in = 3'b111;
      ticks(4);
      check("rev_lvl_99", 32'(m_level[2]), 32'd99);
      ticks(396);
      check("rev_lvl_0", 32'(m_level[2]), 32'd0);
      ticks(1);
      check("rev_set_off", 32'(bus.settled), 32'h7);
      check("rev_pwm_off", 32'(bus.pwm_out), 32'h7);

      // Rotation with saturation: exactly one channel settled-on per phase.
      for (int p = 0; p < 3; p++) begin
         logic [2:0] pat;
         pat = ~(3'b001 << p);
         bus.led_in = pat;
         ticks(1200);
         check("rot_settled", 32'(bus.settled), 32'h7);
         for (int c = 0; c < 3; c++)
            check("rot_level", 32'(m_level[c]), (c == p) ? 32'd255 : 32'd0);
      end

      // Random requests of random length, with occasional resets.
      for (int s = 0; s < 24; s++) begin
         bus.led_in = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 7) == 0) do_reset($urandom_range(1, 4));
         ticks($urandom_range(1, 300));
      end

      @(negedge clk);
      chk_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
